// File: rtl/fifo_word_packer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_word_packer_pkg                                                       |
// | Shared types and helpers for the FIFO word packer.                         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_word_packer_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } pack_state_e;

  function automatic int lanes_cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Output lane that the k-th entry of a word occupies.
  function automatic int lane_index(input int k, input int lanes, input bit msb_first);
    return msb_first ? (lanes - 1 - k) : k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pack_out_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pack_out_reg                                                               |
// | Output holding register with valid/ready handshake for packed words.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pack_out_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_lanes,
  input  logic              word_ready,
  output logic [DATA_W-1:0] word_data,
  output logic [CNT_W-1:0]  word_lanes,
  output logic              word_valid,
  output logic              out_free
);

  assign out_free = !word_valid || word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_valid <= 1'b0;
      word_data  <= '0;
      word_lanes <= '0;
    end else if (load) begin
      word_valid <= 1'b1;
      word_data  <= load_data;
      word_lanes <= load_lanes;
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_word_packer                                                           |
// | Pops narrow FIFO entries and packs LANES of them into one wide word;       |
// | flush emits a partial word. PACKER_MSB_FIRST_EN selects MSB-first lanes.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int MSB   = 3,
  parameter int LSB   = 0,
  parameter int LANES = 8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    fifo_empty,
  output logic                                    fifo_read,
  input  logic [MSB:LSB]                          fifo_data,
  input  logic                                    flush,
  output logic [LANES*(MSB-LSB+1)-1:0]            word_data,
  output logic [lanes_cnt_width(LANES)-1:0]       word_lanes,
  output logic                                    word_valid,
  input  logic                                    word_ready
);

  localparam int W  = MSB - LSB + 1;
  localparam int DW = LANES * W;
  localparam int CW = lanes_cnt_width(LANES);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
`ifdef PACKER_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif

  pack_state_e   state;
  pack_state_e   state_nx;
  logic [DW-1:0] asm_q;
  logic [DW-1:0] asm_cap;
  logic [CW-1:0] fill;
  logic [CW-1:0] fill_cap;
  logic [CW-1:0] occ;
  logic          pend;
  logic          flush_pend;
  logic          out_free;
  logic          full_cap;
  logic          flush_move;
  logic          load;

  assign flush_pend = (state == DRAIN);
  assign fill_cap   = fill + CW'(pend);

  // Assembly contents as they will be once this cycle's capture lands.
  always_comb begin
    asm_cap = asm_q;
    if (pend && (fill < LANES_C)) begin
      asm_cap[lane_index(int'(fill), LANES, MSB_FIRST)*W +: W] = fifo_data;
    end
  end

  assign full_cap   = (fill_cap == LANES_C);
  assign flush_move = flush_pend && !pend && (fill != '0);
  assign load       = out_free && (full_cap || flush_move);

  // A load empties the assembly, so the next read can issue back-to-back.
  assign occ       = load ? '0 : fill_cap;
  assign fifo_read = !reset && !fifo_empty && !flush && !flush_pend && (occ < LANES_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      asm_q <= '0;
      fill  <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_nx;
      pend  <= fifo_read;
      // A load only ever takes a completing capture or an idle assembly.
      if (load) begin
        asm_q <= '0;
        fill  <= '0;
      end else if (pend) begin
        asm_q <= asm_cap;
        fill  <= fill_cap;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      FILL: begin
        if (flush) begin
          state_nx = DRAIN;
        end else if (full_cap && !out_free) begin
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (flush) begin
          state_nx = DRAIN;
        end else if (out_free) begin
          state_nx = FILL;
        end
      end
      DRAIN: begin
        if (!pend && ((fill == '0) || out_free)) begin
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  pack_out_reg #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (asm_cap),
    .load_lanes (fill_cap),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_lanes (word_lanes),
    .word_valid (word_valid),
    .out_free   (out_free)
  );

endmodule
`default_nettype wire
